// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC data/instruction-side interconnect.
// Holds the state encoding, default region map and an index-width helper.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } bus_state_e;

    localparam logic [127:0] DEF_SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                             32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] DEF_SLV_MASK = {4{32'hF000_0000}};

    // Never returns 0 so that single-slave builds still get a 1-bit index.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 1) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/soc_data_bus_if.sv
// Master-side and slave-side signals of the data bus interconnect.
// master: the environment (core plus slave devices); slave: the interconnect itself.
interface soc_data_bus_if #(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
);
    logic                         m_req;
    logic                         m_we;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic [DATA_W/8-1:0]          m_be;
    logic                         m_ready;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_err;

    logic [N_SLAVES-1:0]          s_req;
    logic                         s_we;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [DATA_W/8-1:0]          s_be;
    logic [N_SLAVES-1:0]          s_ready;
    logic [N_SLAVES*DATA_W-1:0]   s_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ready, m_rdata, m_err,
        input  s_req, s_we, s_addr, s_wdata, s_be,
        output s_ready, s_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ready, m_rdata, m_err,
        output s_req, s_we, s_addr, s_wdata, s_be,
        input  s_ready, s_rdata
    );

endinterface

// File: rtl/soc_addr_decode.sv
// Base/mask address decoder; lowest-index region wins on overlap.
module soc_addr_decode
    import soc_bus_pkg::*;
#(
    parameter int unsigned                  N_SLAVES = 4,
    parameter int unsigned                  ADDR_W   = 32,
    parameter int unsigned                  SEL_W    = clog2(N_SLAVES),
    parameter logic [N_SLAVES*ADDR_W-1:0]   BASE     = DEF_SLV_BASE,
    parameter logic [N_SLAVES*ADDR_W-1:0]   MASK     = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [SEL_W-1:0]  o_sel
);

    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (!o_hit && ((i_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/soc_data_bus.sv
// Data-side interconnect: decodes a core access to one of N slaves, waits on
// its ready with an optional timeout, and returns a registered one-cycle completion.
module soc_data_bus
    import soc_bus_pkg::*;
#(
    parameter int unsigned                  N_SLAVES = 4,
    parameter int unsigned                  ADDR_W   = 32,
    parameter int unsigned                  DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned                  TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    soc_data_bus_if.slave     bus,
    output logic [15:0]       err_cnt
);

    localparam int unsigned SEL_W = clog2(N_SLAVES);
    localparam int unsigned TMR_W = clog2(TIMEOUT + 1);
    localparam int unsigned BE_W  = DATA_W / 8;

    bus_state_e          r_state, w_next;
    logic                w_hit;
    logic [SEL_W-1:0]    w_sel;
    logic [SEL_W-1:0]    r_sel;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [TMR_W-1:0]    r_timer;
    logic [DATA_W-1:0]   r_rdata;
    logic [15:0]         r_err_cnt;
    logic                w_load, w_capture, w_tick;
    logic                w_sel_ready, w_timeout;
    logic [DATA_W-1:0]   w_sel_rdata;

    soc_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .SEL_W    (SEL_W),
        .BASE     (SLV_BASE),
        .MASK     (SLV_MASK)
    ) u_decode (
        .i_addr (bus.m_addr),
        .o_hit  (w_hit),
        .o_sel  (w_sel)
    );

    always_comb begin
        w_sel_ready = bus.s_ready[r_sel];
        w_sel_rdata = bus.s_rdata[r_sel*DATA_W +: DATA_W];
        w_timeout   = (TIMEOUT != 0) && (r_timer == TMR_W'(TIMEOUT - 1));
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_tick    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.m_req) begin
                    if (w_hit) begin
                        w_next = BUSY;
                        w_load = 1'b1;
                    end else begin
                        w_next = ERR;
                    end
                end
            end
            // Ready is tested before the timeout so a late ready still completes.
            BUSY: begin
                if (w_sel_ready) begin
                    w_next    = RESP;
                    w_capture = 1'b1;
                end else if (w_timeout) begin
                    w_next = ERR;
                end else begin
                    w_tick = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_timer   <= '0;
            r_rdata   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_sel   <= w_sel;
                r_we    <= bus.m_we;
                r_addr  <= bus.m_addr;
                r_wdata <= bus.m_wdata;
                r_be    <= bus.m_be;
                r_timer <= '0;
            end else if (w_tick) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_capture) begin
                r_rdata <= r_we ? '0 : w_sel_rdata;
            end
            if (r_state == ERR && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        bus.m_ready = (r_state == RESP) || (r_state == ERR);
        bus.m_err   = (r_state == ERR);
        bus.m_rdata = (r_state == RESP) ? r_rdata : '0;
        bus.s_req   = '0;
        if (r_state == BUSY) begin
            bus.s_req[r_sel] = 1'b1;
        end
        bus.s_we    = r_we;
        bus.s_addr  = r_addr;
        bus.s_wdata = r_wdata;
        bus.s_be    = r_be;
        err_cnt     = r_err_cnt;
    end

endmodule

// File: tb/tb_soc_data_bus.sv
// Directed scoreboard bench for soc_data_bus: stimulus pushes expected
// completions, a negedge monitor pops and compares them.
module tb_soc_data_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] err_cnt;

    soc_data_bus_if #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();

    soc_data_bus #(
        .N_SLAVES (4),
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_errcnt = 0;

    typedef struct {
        int unsigned when;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_completion: got m_ready=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("m_err", {31'd0, bus.m_err}, {31'd0, e.err});
                chk("m_rdata", bus.m_rdata, e.rdata);
                chk("completion_cycle", cyc, e.when);
            end
        end
    end

    // One access; sel=-1 for a miss, ready_at/noise_at=-1 for none.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int sel, input int ready_at,
                          input int noise_at, input int noise_slv,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input int unsigned lat);
        int unsigned t0;
        int unsigned k;
        exp_t        e;
        logic [3:0]  onehot;
        @(negedge clk);
        bus.m_we    = we;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        bus.m_be    = be;
        bus.m_req   = 1'b1;
        t0 = cyc;
        e.when  = t0 + lat;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        sb.push_back(e);
        if (exp_err) exp_errcnt++;
        onehot = (sel >= 0) ? 4'(1 << sel) : 4'b0000;
        while (1) begin
            @(negedge clk);
            k = cyc - t0;
            bus.s_ready = '0;
            if (int'(k) == ready_at) bus.s_ready[sel] = 1'b1;
            if (int'(k) == noise_at) bus.s_ready[noise_slv] = 1'b1;
            if (k < lat) begin
                chk("s_req_busy", {28'd0, bus.s_req}, {28'd0, onehot});
                if (sel >= 0) begin
                    chk("s_addr", bus.s_addr, addr);
                    chk("s_wdata", bus.s_wdata, wdata);
                    chk("s_be", {28'd0, bus.s_be}, {28'd0, be});
                    chk("s_we", {31'd0, bus.s_we}, {31'd0, we});
                end
            end else begin
                chk("s_req_done", {28'd0, bus.s_req}, 32'd0);
            end
            if (bus.m_ready === 1'b1) break;
            if (k >= 40) begin
                n_vec++;
                n_miss++;
                $display("FAIL completion_wait: got no m_ready after %0d cycles, expected one at cycle %0d", k, lat);
                break;
            end
        end
        bus.m_req   = 1'b0;
        bus.s_ready = '0;
        @(negedge clk);
        chk("err_cnt", {16'd0, err_cnt}, 32'(exp_errcnt));
    endtask

    initial begin
        rst         = 1'b1;
        bus.m_req   = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_be    = '0;
        bus.s_ready = '0;
        bus.s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEADBEEF, 32'h0000_0A0A};
        repeat (3) @(negedge clk);
        chk("rst_m_ready", {31'd0, bus.m_ready}, 32'd0);
        chk("rst_m_rdata", bus.m_rdata, 32'd0);
        chk("rst_s_req", {28'd0, bus.s_req}, 32'd0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        rst = 1'b0;

        // zero-wait read of slave 1
        access(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1, 1, -1, 0, 1'b0, 32'hDEADBEEF, 2);
        // write to slave 2 with 3 wait cycles; writes return 0
        access(1'b1, 32'h2000_0004, 32'h1234_5678, 4'b0011, 2, 4, -1, 0, 1'b0, 32'h0, 5);
        // unmapped
        access(1'b0, 32'h8000_0000, 32'h0, 4'hF, -1, -1, -1, 0, 1'b1, 32'h0, 1);
        // slave 3 never ready -> timeout
        access(1'b0, 32'h3000_0100, 32'h0, 4'hF, 3, -1, -1, 0, 1'b1, 32'h0, 16);
        // stray s_ready[0], then s_ready[1] on the timeout cycle
        access(1'b0, 32'h1000_0020, 32'h0, 4'hF, 1, 15, 2, 0, 1'b0, 32'hDEADBEEF, 16);

        // reset during BUSY on slave 2
        @(negedge clk);
        bus.m_we    = 1'b1;
        bus.m_addr  = 32'h2000_0008;
        bus.m_wdata = 32'hCAFE_F00D;
        bus.m_be    = 4'hF;
        bus.m_req   = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_s_req", {28'd0, bus.s_req}, 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_s_req", {28'd0, bus.s_req}, 32'd0);
        chk("rst_busy_m_ready", {31'd0, bus.m_ready}, 32'd0);
        chk("rst_busy_m_err", {31'd0, bus.m_err}, 32'd0);
        chk("rst_busy_s_addr", bus.s_addr, 32'd0);
        chk("rst_busy_s_wdata", bus.s_wdata, 32'd0);
        chk("rst_busy_s_be_we", {27'd0, bus.s_we, bus.s_be}, 32'd0);
        chk("rst_busy_err_cnt", {16'd0, err_cnt}, 32'd0);
        exp_errcnt = 0;
        bus.m_req  = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // normal read of slave 0 after reset
        access(1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1, -1, 0, 1'b0, 32'h0000_0A0A, 2);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
